if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It holds the program counter and the IF/ID pipeline register, and selects the next PC from three sources: sequential fetch, J/JAL/JR/JALR redirect and taken-branch redirect. It consumes the stall and flush controls driven by the hazard unit. It also keeps three performance counters that record fetch efficiency.

## Interface
- RESET_PC, 32'h0040_0000: PC value loaded on reset.
- CNT_W, 32: width of each performance counter.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- PC_Wr_en  in  1  from hazard unit; 0 holds PC (load-use stall).
- IF_ID_Wr_en  in  1  from hazard unit; 0 holds IF/ID.
- IF_ID_flush  in  1  from hazard unit; loads a bubble into IF/ID.
- Branch_hazard  in  1  taken branch resolved in EX.
- Branch_target  in  32  branch destination from EX.
- rs_forward  in  32  forwarded rs value of the IF/ID instruction (JR/JALR target).
- Instr_data  in  32  instruction-memory read data for Instr_addr (combinational ROM).
- Instr_addr  out  32  current PC.
- IF_ID_Instruction  out  32  registered instruction.
- IF_ID_PC_plus_4  out  32  registered PC+4 of that instruction.
- IF_ID_valid  out  1  0 marks a bubble.
- IF_ID_OpCode, IF_ID_Funct  out  6 each  bits [31:26] and [5:0] of IF_ID_Instruction.
- Stall_count, Flush_count, Fetch_count  out  CNT_W each  performance counters.

## Operation
- Jump decode of IF/ID (jmp) is true for any of:
  - opcode 6'h02 (J) or 6'h03 (JAL), target {IF_ID_PC_plus_4[31:28], instr[25:0], 2'b00};
  - opcode 6'h00 with funct 6'h08 (JR) or 6'h09 (JALR), target rs_forward.
- Next-PC priority, highest first:
  - reset → RESET_PC;
  - Branch_hazard → Branch_target, even when PC_Wr_en=0, because the EX branch is older than any ID stall;
  - PC_Wr_en=0 → hold;
  - jmp && IF_ID_Wr_en → jump target;
  - otherwise PC+4.
- IF/ID update, highest priority first:
  - reset → instruction 32'h0, PC+4 0, valid 0;
  - IF_ID_flush → the same bubble values, overriding IF_ID_Wr_en;
  - IF_ID_Wr_en → {Instr_data, PC+4, 1};
  - otherwise hold.
- The IF_ID_valid=0 bubble is an all-zero word, which decodes as sll $0 and is harmless downstream.
- The jump target is consumed only when IF_ID_Wr_en=1. A JR stalled on a load therefore uses rs_forward only after the hazard unit releases it.
- Counters, each wrapping modulo 2^CNT_W and cleared by reset:
  - Stall_count +1 when PC_Wr_en=0 and Branch_hazard=0;
  - Flush_count +1 when IF_ID_flush=1;
  - Fetch_count +1 when IF/ID loads a valid instruction.
- PC arithmetic is 32-bit and wraps at 32'hFFFF_FFFC+4 → 0. Bits [1:0] are never checked.

## Timing
- Reset values:
  - Instr_addr = RESET_PC;
  - IF_ID_Instruction = 0, IF_ID_PC_plus_4 = 0, IF_ID_valid = 0;
  - opcode and funct outputs = 0;
  - all counters = 0.
- Fetch latency is 1 cycle: Instr_data at PC=A is visible on IF_ID_* in the cycle after the edge that leaves A.
- Jump penalty is 1 bubble. The wrong-path fetch is squashed by IF_ID_flush in the same cycle the jump sits in ID.
- Taken-branch penalty is 2 bubbles. IF/ID is flushed here, and ID/EX is flushed by the hazard unit.
- Simultaneous events:
  - Branch_hazard and jmp together: the branch wins and the jump is discarded.
  - Stall and flush together: the flush wins in IF/ID; the PC still holds unless Branch_hazard is 1.
- Reset asserted mid-stall or mid-redirect: the next edge restores all reset values unconditionally.

## Structure
- Shared package `mips_pkg` holds:
  - OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03;
  - FN_JR=6'h08, FN_JALR=6'h09;
  - NOP_INSTR=32'h0, DEFAULT_RESET_PC.
- The hazard unit must import the same constants.
- One sub-module, `pc_next_sel`: combinational next-PC priority mux plus jump decode.
- The registers and counters stay in `if_stage`.

## Test plan
- Reset: hold reset for 2 cycles, then release.
  - During reset: Instr_addr=32'h0040_0000, IF_ID_valid=0, all counters 0.
  - After release: Instr_addr steps 0x00400000, 0x00400004, 0x00400008 on successive cycles.
- J: J with instr[25:0]=0x0100010 fetched at 0x00400008, with the hazard unit flushing.
  - The next PC is 0x00400040.
  - Exactly 1 bubble appears in IF/ID (IF_ID_valid=0).
  - Flush_count becomes 1.
- Load-use stall: PC_Wr_en=IF_ID_Wr_en=0 for 1 cycle.
  - PC and IF/ID hold their values.
  - Stall_count increments by 1.
  - The pipeline resumes at PC+4 afterwards with no lost instruction.
- JR stalled on a load: JR in ID with rs_forward=0x00400100, first under a 1-cycle stall, then released.
  - The PC jumps to 0x00400100 only on the release cycle.
- Branch collisions:
  - Branch_hazard=1 with Branch_target=0x00400200 while PC_Wr_en=0 and a J sits in IF/ID: the PC becomes 0x00400200 and IF_ID_valid=0 next cycle.
  - Reset asserted in that same cycle instead: the PC becomes RESET_PC.
- Counter wrap: run with CNT_W=4 and 17 valid fetches.
  - Fetch_count=1 after the 17th fetch.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Opcode/funct constants, next-PC source encoding and jump
//                decode helpers shared by the fetch stage and hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE         = 6'h00;
    localparam logic [5:0]  OP_J             = 6'h02;
    localparam logic [5:0]  OP_JAL           = 6'h03;
    localparam logic [5:0]  FN_JR            = 6'h08;
    localparam logic [5:0]  FN_JALR          = 6'h09;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // Source chosen for the next program counter, highest priority first
    typedef enum logic [2:0] {
        PC_SEL_RESET  = 3'd0,
        PC_SEL_BRANCH = 3'd1,
        PC_SEL_HOLD   = 3'd2,
        PC_SEL_JUMP   = 3'd3,
        PC_SEL_SEQ    = 3'd4
    } pc_sel_e;

    // Absolute jump (J/JAL) with a 26-bit pseudo-direct target
    function automatic logic is_abs_jump(input logic [31:0] instr);
        return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
    endfunction

    // Register jump (JR/JALR) whose target is the forwarded rs value
    function automatic logic is_reg_jump(input logic [31:0] instr);
        return (instr[31:26] == OP_RTYPE) &&
               ((instr[5:0] == FN_JR) || (instr[5:0] == FN_JALR));
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Combinational next-PC priority mux with jump decode of the
//                instruction currently held in IF/ID.
//  Revision    : 1.0 - initial release
// ============================================================================
import mips_pkg::*;

module pc_next_sel #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          reset,
    input  logic          PC_Wr_en,
    input  logic          IF_ID_Wr_en,
    input  logic          Branch_hazard,
    input  logic [31:0]   Branch_target,
    input  logic [31:0]   rs_forward,
    input  logic [31:0]   pc_q,
    input  logic [31:0]   if_id_instr,
    input  logic [3:0]    if_id_pc4_hi,
    output logic          jmp,
    output logic [31:0]   jmp_target,
    output pc_sel_e       pc_sel,
    output logic [31:0]   pc_d
);

    // Decode the ID-stage instruction into a jump flag and its target
    always_comb begin
        jmp        = 1'b0;
        jmp_target = rs_forward;
        if (is_abs_jump(if_id_instr)) begin
            jmp        = 1'b1;
            jmp_target = {if_id_pc4_hi, if_id_instr[25:0], 2'b00};
        end else if (is_reg_jump(if_id_instr)) begin
            jmp        = 1'b1;
            jmp_target = rs_forward;
        end
    end

    // Pick the next PC; the EX branch is older than any ID stall so it
    // overrides the hold, and a jump waits until IF/ID is allowed to move
    always_comb begin
        pc_sel = PC_SEL_SEQ;
        pc_d   = pc_q + 32'd4;
        if (reset) begin
            pc_sel = PC_SEL_RESET;
            pc_d   = RESET_PC;
        end else if (Branch_hazard) begin
            pc_sel = PC_SEL_BRANCH;
            pc_d   = Branch_target;
        end else if (!PC_Wr_en) begin
            pc_sel = PC_SEL_HOLD;
            pc_d   = pc_q;
        end else if (jmp && IF_ID_Wr_en) begin
            pc_sel = PC_SEL_JUMP;
            pc_d   = jmp_target;
        end
    end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : MIPS instruction-fetch stage: program counter, IF/ID
//                pipeline register and fetch-efficiency counters.
//  Revision    : 1.0 - initial release
// ============================================================================
import mips_pkg::*;

module if_stage #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PC_Wr_en,
    input  logic               IF_ID_Wr_en,
    input  logic               IF_ID_flush,
    input  logic               Branch_hazard,
    input  logic [31:0]        Branch_target,
    input  logic [31:0]        rs_forward,
    input  logic [31:0]        Instr_data,
    output logic [31:0]        Instr_addr,
    output logic [31:0]        IF_ID_Instruction,
    output logic [31:0]        IF_ID_PC_plus_4,
    output logic               IF_ID_valid,
    output logic [5:0]         IF_ID_OpCode,
    output logic [5:0]         IF_ID_Funct,
    output logic [CNT_W-1:0]   Stall_count,
    output logic [CNT_W-1:0]   Flush_count,
    output logic [CNT_W-1:0]   Fetch_count
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_plus_4;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic             fetch_load;
    logic             jmp;
    logic [31:0]      jmp_target;
    pc_sel_e          pc_sel;

    pc_next_sel #(
        .RESET_PC      (RESET_PC)
    ) u_pc_next_sel (
        .reset         (reset),
        .PC_Wr_en      (PC_Wr_en),
        .IF_ID_Wr_en   (IF_ID_Wr_en),
        .Branch_hazard (Branch_hazard),
        .Branch_target (Branch_target),
        .rs_forward    (rs_forward),
        .pc_q          (pc_q),
        .if_id_instr   (instr_q),
        .if_id_pc4_hi  (pc4_q[31:28]),
        .jmp           (jmp),
        .jmp_target    (jmp_target),
        .pc_sel        (pc_sel),
        .pc_d          (pc_d)
    );

    // IF/ID next state: flush wins over write enable, otherwise hold
    always_comb begin
        pc_plus_4  = pc_q + 32'd4;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        fetch_load = 1'b0;
        if (IF_ID_flush) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (IF_ID_Wr_en) begin
            instr_d    = Instr_data;
            pc4_d      = pc_plus_4;
            valid_d    = 1'b1;
            fetch_load = 1'b1;
        end
    end

    // Performance counters; a branch redirect during a stall is not a stall
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        if (!PC_Wr_en && !Branch_hazard) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (IF_ID_flush) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (fetch_load) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            fetch_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Jump decode outputs are only needed by the mux; keep them observable
    // for debug without feeding further logic
    logic unused_dbg;
    assign unused_dbg = ^{jmp, jmp_target, pc_sel};

    assign Instr_addr        = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PC_plus_4   = pc4_q;
    assign IF_ID_valid       = valid_q;
    assign IF_ID_OpCode      = instr_q[31:26];
    assign IF_ID_Funct       = instr_q[5:0];
    assign Stall_count       = stall_cnt_q;
    assign Flush_count       = flush_cnt_q;
    assign Fetch_count       = fetch_cnt_q;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage with an instruction ROM,
//                a reference model and an IF/ID scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PC_Wr_en = 1'b1, IF_ID_Wr_en = 1'b1, IF_ID_flush = 1'b0;
    logic        Branch_hazard = 1'b0;
    logic [31:0] Branch_target = 32'h0, rs_forward = 32'h0;
    logic [31:0] Instr_data, Instr_addr, IF_ID_Instruction, IF_ID_PC_plus_4;
    logic        IF_ID_valid;
    logic [5:0]  IF_ID_OpCode, IF_ID_Funct;
    logic [31:0] Stall_count, Flush_count, Fetch_count;

    logic [31:0] s_Instr_data, s_Instr_addr, s_instr, s_pc4;
    logic        s_valid;
    logic [5:0]  s_op, s_fn;
    logic [3:0]  s_stall, s_flush, s_fetch;

    always #5 clk = ~clk;

    // Instruction ROM: a few jumps at fixed spots, everything else addi
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0040_0008: return {6'h02, 26'h010_0010};             // J 0x00400040
            32'h0040_0048: return {6'h00, 5'd8, 15'd0, 6'h08};       // JR $8
            32'h0040_0100: return {6'h02, 26'h010_0050};             // J 0x00400140
            32'h0040_0200: return {6'h02, 26'h010_0090};             // J 0x00400240
            default:       return {6'h08, 10'h000, a[17:2]};         // addi
        endcase
    endfunction

    assign Instr_data   = rom(Instr_addr);
    assign s_Instr_data = rom(s_Instr_addr);

    if_stage #(.RESET_PC(C_RESET_PC), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .PC_Wr_en(PC_Wr_en), .IF_ID_Wr_en(IF_ID_Wr_en),
        .IF_ID_flush(IF_ID_flush), .Branch_hazard(Branch_hazard),
        .Branch_target(Branch_target), .rs_forward(rs_forward),
        .Instr_data(Instr_data), .Instr_addr(Instr_addr),
        .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC_plus_4(IF_ID_PC_plus_4),
        .IF_ID_valid(IF_ID_valid), .IF_ID_OpCode(IF_ID_OpCode), .IF_ID_Funct(IF_ID_Funct),
        .Stall_count(Stall_count), .Flush_count(Flush_count), .Fetch_count(Fetch_count)
    );

    if_stage #(.RESET_PC(C_RESET_PC), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .PC_Wr_en(PC_Wr_en), .IF_ID_Wr_en(IF_ID_Wr_en),
        .IF_ID_flush(IF_ID_flush), .Branch_hazard(Branch_hazard),
        .Branch_target(Branch_target), .rs_forward(rs_forward),
        .Instr_data(s_Instr_data), .Instr_addr(s_Instr_addr),
        .IF_ID_Instruction(s_instr), .IF_ID_PC_plus_4(s_pc4),
        .IF_ID_valid(s_valid), .IF_ID_OpCode(s_op), .IF_ID_Funct(s_fn),
        .Stall_count(s_stall), .Flush_count(s_flush), .Fetch_count(s_fetch)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model state
    logic [31:0] m_pc = C_RESET_PC, m_ir = 32'h0, m_p4 = 32'h0;
    logic        m_v = 1'b0;
    logic [31:0] m_stall = 0, m_flush = 0, m_fetch = 0;
    logic [63:0] sb[$];

    // Drive one cycle of controls, advance model and DUT, compare
    task automatic tick(input logic r, input logic pw, input logic iw, input logic fl,
                        input logic bh, input logic [31:0] bt, input logic [31:0] rsf);
        logic        jm;
        logic [31:0] jt, npc;
        logic        loaded;
        reset = r; PC_Wr_en = pw; IF_ID_Wr_en = iw; IF_ID_flush = fl;
        Branch_hazard = bh; Branch_target = bt; rs_forward = rsf;
        jm = 1'b0; jt = 32'h0;
        if (m_ir[31:26] == 6'h02 || m_ir[31:26] == 6'h03) begin
            jm = 1'b1; jt = {m_p4[31:28], m_ir[25:0], 2'b00};
        end else if (m_ir[31:26] == 6'h00 && (m_ir[5:0] == 6'h08 || m_ir[5:0] == 6'h09)) begin
            jm = 1'b1; jt = rsf;
        end
        if (r)             npc = C_RESET_PC;
        else if (bh)       npc = bt;
        else if (!pw)      npc = m_pc;
        else if (jm && iw) npc = jt;
        else               npc = m_pc + 32'd4;
        loaded = !r && !fl && iw;
        if (loaded) sb.push_back({rom(m_pc), m_pc + 32'd4});
        @(posedge clk);
        #1;
        if (r) begin
            m_ir = 0; m_p4 = 0; m_v = 0; m_stall = 0; m_flush = 0; m_fetch = 0;
        end else begin
            if (!pw && !bh) m_stall++;
            if (fl) begin m_flush++; m_ir = 0; m_p4 = 0; m_v = 0; end
            else if (iw) begin
                m_fetch++;
                {m_ir, m_p4} = sb.pop_front();
                m_v = 1'b1;
            end
        end
        m_pc = npc;
        chk("pc", Instr_addr, m_pc);
        chk("ifid_instr", IF_ID_Instruction, m_ir);
        chk("ifid_pc4", IF_ID_PC_plus_4, m_p4);
        chk("ifid_valid", {31'd0, IF_ID_valid}, {31'd0, m_v});
        chk("opcode", {26'd0, IF_ID_OpCode}, {26'd0, m_ir[31:26]});
        chk("funct", {26'd0, IF_ID_Funct}, {26'd0, m_ir[5:0]});
        chk("stall_cnt", Stall_count, m_stall);
        chk("flush_cnt", Flush_count, m_flush);
        chk("fetch_cnt", Fetch_count, m_fetch);
        chk("small_fetch", {28'd0, s_fetch}, {28'd0, m_fetch[3:0]});
        chk("small_stall", {28'd0, s_stall}, {28'd0, m_stall[3:0]});
    endtask

    task automatic run(input logic pw, input logic iw, input logic fl);
        tick(1'b0, pw, iw, fl, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        // Reset for two cycles
        tick(1'b1, 1, 1, 0, 0, 32'h0, 32'h0);
        tick(1'b1, 1, 1, 0, 0, 32'h0, 32'h0);
        chk("rst_pc", Instr_addr, 32'h0040_0000);
        chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rst_fetch", Fetch_count, 32'd0);

        // Sequential stepping after release
        run(1, 1, 0);
        chk("seq_pc1", Instr_addr, 32'h0040_0004);
        run(1, 1, 0);
        chk("seq_pc2", Instr_addr, 32'h0040_0008);

        // J fetched at 0x00400008, flushed when it sits in ID
        run(1, 1, 0);
        chk("j_in_id", {26'd0, IF_ID_OpCode}, 32'h02);
        run(1, 1, 1);
        chk("j_target", Instr_addr, 32'h0040_0040);
        chk("j_bubble", {31'd0, IF_ID_valid}, 32'd0);
        chk("j_flush_cnt", Flush_count, 32'd1);
        run(1, 1, 0);
        chk("j_resume", {31'd0, IF_ID_valid}, 32'd1);

        // Load-use stall for one cycle
        run(0, 0, 0);
        chk("stall_pc", Instr_addr, 32'h0040_0044);
        chk("stall_cnt1", Stall_count, 32'd1);
        run(1, 1, 0);
        chk("stall_resume", IF_ID_PC_plus_4, 32'h0040_0048);

        // JR in ID, stalled one cycle, then released
        run(1, 1, 0);
        tick(1'b0, 0, 0, 0, 0, 32'h0, 32'h0040_0100);
        chk("jr_stalled", Instr_addr, 32'h0040_004C);
        tick(1'b0, 1, 1, 1, 0, 32'h0, 32'h0040_0100);
        chk("jr_release", Instr_addr, 32'h0040_0100);

        // Branch collides with a stall and a J in ID
        run(1, 1, 0);
        tick(1'b0, 0, 1, 1, 1, 32'h0040_0200, 32'h0);
        chk("br_pc", Instr_addr, 32'h0040_0200);
        chk("br_bubble", {31'd0, IF_ID_valid}, 32'd0);

        // Same collision with reset asserted instead
        run(1, 1, 0);
        tick(1'b1, 0, 1, 1, 1, 32'h0040_0200, 32'h0);
        chk("rst_collide_pc", Instr_addr, C_RESET_PC);
        chk("rst_collide_stall", Stall_count, 32'd0);

        // Seventeen valid fetches wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) run(1, 1, 0);
        chk("wrap_small", {28'd0, s_fetch}, 32'd1);
        chk("wrap_big", Fetch_count, 32'd17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire
